// File: rtl/parallax_scroll.sv
// Multi-layer scroll-position generator: one accelerating tick timer, NUM_LAYERS wrapping positions.
// Optional single-step while frozen: define PARALLAX_SCROLL_STEP_EN to add the step input.
//
// state  | meaning
// -------+-----------------------------------------------
// RUN    | timer counts, tick events advance enabled layers
// FROZEN | halt high: everything holds, step may force one event

module parallax_scroll #(
    parameter int NUM_LAYERS    = 3,
    parameter int POS_W         = 11,
    parameter int CTR_W         = 18,
    parameter int INITIAL_SPEED = 250000,
    parameter int MIN_TICK      = 50000,
    parameter int WRAP_LIMIT    = 1280
) (
    input  logic                        clk,
    input  logic                        sys_rst,
    input  logic                        game_rst,
    input  logic                        halt,
    input  logic [7:0]                  speed_change,
    input  logic [8*NUM_LAYERS-1:0]     move_amt,
    input  logic [NUM_LAYERS-1:0]       layer_en,
`ifdef PARALLAX_SCROLL_STEP_EN
    input  logic                        step,
`endif
    output logic [POS_W*NUM_LAYERS-1:0] pos,
    output logic [23:0]                 speed,
    output logic                        tick,
    output logic [NUM_LAYERS-1:0]       wrap
);

    localparam logic [CTR_W-1:0] INIT_TT = CTR_W'(INITIAL_SPEED);
    localparam logic [CTR_W-1:0] MIN_TT  = CTR_W'(MIN_TICK);
    localparam logic [POS_W:0]   WRAP_L  = (POS_W+1)'(WRAP_LIMIT);

    typedef enum logic {RUN, FROZEN} state_t;

    state_t                state;
    logic                  rst;
    logic                  fire;
    logic                  step_rise;
    logic [CTR_W-1:0]      ctr;
    logic [CTR_W-1:0]      tick_time;
    logic [CTR_W-1:0]      tick_time_nxt;
    logic [CTR_W-1:0]      speed_q;
    logic [CTR_W:0]        dec;
    logic [POS_W-1:0]      pos_r   [NUM_LAYERS];
    logic [POS_W-1:0]      pos_nxt [NUM_LAYERS];
    logic [POS_W:0]        sum     [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] wrap_hit;

    assign rst = sys_rst | game_rst;

`ifdef PARALLAX_SCROLL_STEP_EN
    logic step_q;

    always_ff @(posedge clk) begin
        step_q <= step;
    end

    assign step_rise = step & ~step_q;
`else
    assign step_rise = 1'b0;
`endif

    // halt is used directly so a tick coinciding with halt is deferred, not lost
    assign fire = halt ? ((state == FROZEN) && step_rise) : (ctr >= tick_time);

    // One extra bit so a large speed_change saturates instead of wrapping
    always_comb begin
        dec = {1'b0, tick_time} - (CTR_W+1)'(speed_change);
        if (dec[CTR_W] || (dec[CTR_W-1:0] < MIN_TT))
            tick_time_nxt = MIN_TT;
        else
            tick_time_nxt = dec[CTR_W-1:0];
    end

    always_comb begin
        wrap_hit = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            sum[i]     = {1'b0, pos_r[i]} + (POS_W+1)'(move_amt[8*i +: 8]);
            pos_nxt[i] = pos_r[i];
            if (layer_en[i]) begin
                if (sum[i] >= WRAP_L) begin
                    pos_nxt[i]  = POS_W'(sum[i] - WRAP_L);
                    wrap_hit[i] = 1'b1;
                end else begin
                    pos_nxt[i] = POS_W'(sum[i]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            ctr       <= '0;
            tick_time <= INIT_TT;
            speed_q   <= INIT_TT;
            tick      <= 1'b0;
            wrap      <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) pos_r[i] <= '0;
        end else begin
            state   <= halt ? FROZEN : RUN;
            speed_q <= tick_time;
            tick    <= 1'b0;
            wrap    <= '0;
            if (fire) begin
                ctr       <= '0;
                tick      <= 1'b1;
                tick_time <= tick_time_nxt;
                wrap      <= wrap_hit;
                for (int i = 0; i < NUM_LAYERS; i++) pos_r[i] <= pos_nxt[i];
            end else if (!halt) begin
                ctr <= ctr + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_pack
        assign pos[g*POS_W +: POS_W] = pos_r[g];
    end

    assign speed = 24'(speed_q);

endmodule

// File: tb/tb_parallax_scroll.sv
// Directed self-checking bench for parallax_scroll with a short tick period.
module tb_parallax_scroll;

    localparam int NL   = 3;
    localparam int PW   = 11;
    localparam int CW   = 18;
    localparam int INIT = 10;
    localparam int MINT = 4;
    localparam int WL   = 1280;

    logic            clk = 1'b0;
    logic            sys_rst = 1'b1;
    logic            game_rst = 1'b0;
    logic            halt = 1'b0;
    logic [7:0]      speed_change = '0;
    logic [8*NL-1:0] move_amt = '0;
    logic [NL-1:0]   layer_en = '0;
`ifdef PARALLAX_SCROLL_STEP_EN
    logic            step = 1'b0;
`endif
    logic [PW*NL-1:0] pos;
    logic [23:0]      speed;
    logic             tick;
    logic [NL-1:0]    wrap;

    int errors = 0;
    int checks = 0;

    parallax_scroll #(
        .NUM_LAYERS(NL), .POS_W(PW), .CTR_W(CW),
        .INITIAL_SPEED(INIT), .MIN_TICK(MINT), .WRAP_LIMIT(WL)
    ) dut (
        .clk(clk), .sys_rst(sys_rst), .game_rst(game_rst), .halt(halt),
        .speed_change(speed_change), .move_amt(move_amt), .layer_en(layer_en),
`ifdef PARALLAX_SCROLL_STEP_EN
        .step(step),
`endif
        .pos(pos), .speed(speed), .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit use_game);
        if (use_game) game_rst = 1'b1;
        else          sys_rst  = 1'b1;
        cyc;
        game_rst = 1'b0;
        sys_rst  = 1'b0;
    endtask

    task automatic wait_tick(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            cyc;
            if (tick === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: tick stayed 0 for 40 cycles, required 1", name);
        end
    endtask

    task automatic test_reset;
        sys_rst = 1'b1;
        halt    = 1'b1;
        cyc;
        cyc;
        checks++;
        if (pos !== '0 || tick !== 1'b0 || wrap !== '0 || speed !== 24'(INIT)) begin
            errors++;
            $display("FAIL reset_state: pos=%0h tick=%b wrap=%b speed=%0d, required 0 0 0 %0d",
                     pos, tick, wrap, speed, INIT);
        end
        halt    = 1'b0;
        sys_rst = 1'b0;
    endtask

    task automatic test_period;
        int exp_speed;
        bit exp_tick;
        speed_change = 8'd3;
        move_amt     = '0;
        layer_en     = '0;
        do_reset(1'b0);
        for (int n = 1; n <= 30; n++) begin
            cyc;
            exp_tick = (n == 11 || n == 19 || n == 24 || n == 29);
            checks++;
            if (tick !== exp_tick) begin
                errors++;
                $display("FAIL period_tick c%0d: tick=%b, required %b", n, tick, exp_tick);
            end
            if (exp_tick || n == 12) begin
                exp_speed = (n == 11) ? 10 : (n == 12 || n == 19) ? 7 : 4;
                checks++;
                if (speed !== 24'(exp_speed)) begin
                    errors++;
                    $display("FAIL period_speed c%0d: speed=%0d, required %0d", n, speed, exp_speed);
                end
            end
        end
    endtask

    task automatic test_wrap;
        int exp_pos;
        speed_change = 8'd0;
        move_amt     = 24'd200;
        layer_en     = 3'b001;
        do_reset(1'b0);
        for (int k = 1; k <= 7; k++) begin
            wait_tick("wrap_tick");
            exp_pos = (k == 7) ? 120 : k * 200;
            checks++;
            if (pos[PW-1:0] !== PW'(exp_pos) || wrap !== ((k == 7) ? 3'b001 : 3'b000)
                || pos[PW*NL-1:PW] !== '0) begin
                errors++;
                $display("FAIL wrap_step k%0d: pos0=%0d wrap=%b upper=%0h, required %0d %b 0",
                         k, pos[PW-1:0], wrap, pos[PW*NL-1:PW], exp_pos, (k == 7) ? 3'b001 : 3'b000);
            end
        end
        cyc;
        checks++;
        if (wrap !== 3'b000 || tick !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pulse_width: wrap=%b tick=%b, required 000 0", wrap, tick);
        end
    endtask

    task automatic test_layers;
        logic [PW*NL-1:0] exp_pos;
        speed_change = 8'd0;
        move_amt     = {8'd3, 8'd2, 8'd1};
        layer_en     = 3'b101;
        do_reset(1'b0);
        for (int k = 1; k <= 5; k++) begin
            wait_tick("layers_tick");
            checks++;
            if (wrap !== 3'b000) begin
                errors++;
                $display("FAIL layers_wrap k%0d: wrap=%b, required 000", k, wrap);
            end
        end
        exp_pos = {11'd15, 11'd0, 11'd5};
        checks++;
        if (pos !== exp_pos) begin
            errors++;
            $display("FAIL layers_pos: pos=%0h, required %0h", pos, exp_pos);
        end
    endtask

    task automatic test_halt;
        speed_change = 8'd0;
        move_amt     = 24'd7;
        layer_en     = 3'b001;
        do_reset(1'b0);
        for (int n = 1; n <= 10; n++) begin
            cyc;
            checks++;
            if (tick !== 1'b0) begin
                errors++;
                $display("FAIL halt_pre c%0d: tick=%b, required 0", n, tick);
            end
        end
        halt = 1'b1;
        for (int n = 0; n < 100; n++) begin
            cyc;
            checks++;
            if (tick !== 1'b0 || pos[PW-1:0] !== '0) begin
                errors++;
                $display("FAIL halt_hold h%0d: tick=%b pos0=%0d, required 0 0", n, tick, pos[PW-1:0]);
            end
        end
        halt = 1'b0;
        cyc;
        checks++;
        if (tick !== 1'b1 || pos[PW-1:0] !== 11'd7) begin
            errors++;
            $display("FAIL halt_release: tick=%b pos0=%0d, required 1 7", tick, pos[PW-1:0]);
        end
    endtask

    task automatic test_reset_mid(input bit use_game, input string name);
        speed_change = 8'd3;
        move_amt     = 24'd100;
        layer_en     = 3'b001;
        do_reset(1'b0);
        for (int k = 0; k < 7; k++) wait_tick(name);
        checks++;
        if (pos[PW-1:0] !== 11'd700) begin
            errors++;
            $display("FAIL %s_pre: pos0=%0d, required 700", name, pos[PW-1:0]);
        end
        do_reset(use_game);
        checks++;
        if (pos !== '0 || speed !== 24'(INIT) || tick !== 1'b0 || wrap !== '0) begin
            errors++;
            $display("FAIL %s_post: pos=%0h speed=%0d tick=%b wrap=%b, required 0 %0d 0 0",
                     name, pos, speed, tick, wrap, INIT);
        end
        cyc;
        checks++;
        if (tick !== 1'b0 || pos !== '0) begin
            errors++;
            $display("FAIL %s_residual: tick=%b pos=%0h, required 0 0", name, tick, pos);
        end
    endtask

`ifdef PARALLAX_SCROLL_STEP_EN
    task automatic test_step;
        speed_change = 8'd3;
        move_amt     = 24'd5;
        layer_en     = 3'b001;
        do_reset(1'b0);
        halt = 1'b1;
        cyc;
        cyc;
        cyc;
        step = 1'b1;
        cyc;
        checks++;
        if (tick !== 1'b1 || pos[PW-1:0] !== 11'd5) begin
            errors++;
            $display("FAIL step_first: tick=%b pos0=%0d, required 1 5", tick, pos[PW-1:0]);
        end
        cyc;
        checks++;
        if (tick !== 1'b0 || speed !== 24'd7 || pos[PW-1:0] !== 11'd5) begin
            errors++;
            $display("FAIL step_held: tick=%b speed=%0d pos0=%0d, required 0 7 5", tick, speed, pos[PW-1:0]);
        end
        step = 1'b0;
        cyc;
        step = 1'b1;
        cyc;
        checks++;
        if (tick !== 1'b1 || pos[PW-1:0] !== 11'd10) begin
            errors++;
            $display("FAIL step_second: tick=%b pos0=%0d, required 1 10", tick, pos[PW-1:0]);
        end
        step = 1'b0;
        cyc;
        checks++;
        if (tick !== 1'b0 || speed !== 24'd4) begin
            errors++;
            $display("FAIL step_speed: tick=%b speed=%0d, required 0 4", tick, speed);
        end
        halt = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_period;
        test_wrap;
        test_layers;
        test_halt;
        test_reset_mid(1'b1, "game_rst");
        test_reset_mid(1'b0, "sys_rst");
`ifdef PARALLAX_SCROLL_STEP_EN
        test_step;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
